max3_stream_ctrl: RTL and testbench

Sequencer that owns the shared max-of-three selector and feeds it from a single valid/ready sample stream. It collects three consecutive samples into operand registers A, B, C, presents the selected maximum and its winning slot index on a valid/ready output port, then returns for the next triple. It sits between a sample producer and any consumer of per-triple peaks. An optional running-peak tracker spans all completed triples.

---
 rtl/max3_pkg.sv | 18 +
 rtl/max3_stream_ctrl_if.sv | 24 ++
 rtl/max3_sel.sv | 26 ++
 rtl/max3_stream_ctrl.sv | 90 +++++++++
 tb/tb_max3_stream_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max3_pkg.sv
// Shared definitions for the max-of-three stream sequencer and its selector:
// FSM state encoding, default sample width and winning-slot index constants.
package max3_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_C   = 2'd2,
    S_OUT = 2'd3
  } state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

endpackage

// File: rtl/max3_stream_ctrl_if.sv
// Sample-in / result-out bus of max3_stream_ctrl.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. A source holds data stable while valid=1 and ready=0; ready never
// depends combinationally on valid in this block.
// master = producer/consumer side, slave = max3_stream_ctrl.
interface max3_stream_ctrl_if #(parameter int W = max3_pkg::W);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_valid
  );
endinterface

// File: rtl/max3_sel.sv
// Combinational max-of-three selector. Unsigned compare, ties resolved with
// priority A > B > C, so the lowest slot holding the maximum wins.
module max3_sel #(
  parameter int W = max3_pkg::W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_max,
  output logic [1:0]   o_idx
);
  import max3_pkg::*;

  // Pick the winner; >= gives the earlier slot the tie.
  always_comb begin
    o_max = i_c;
    o_idx = IDX_C;
    if (i_a >= i_b && i_a >= i_c) begin
      o_max = i_a;
      o_idx = IDX_A;
    end else if (i_b >= i_c) begin
      o_max = i_b;
      o_idx = IDX_B;
    end
  end
endmodule

// File: rtl/max3_stream_ctrl.sv
// Collects three samples into A, B, C, then offers their maximum and the
// winning slot on the output port until the consumer takes it.
// Optional running peak across completed triples: define MAX3_RUNNING_EN.
module max3_stream_ctrl #(
  parameter int W = max3_pkg::W
) (
  input  logic               clk,
  input  logic               rst,
  max3_stream_ctrl_if.slave  bus,
`ifdef MAX3_RUNNING_EN
  input  logic               run_clr,
  output logic [W-1:0]       run_max,
`endif
  output logic [1:0]         o_dbg_state
);
  import max3_pkg::*;

  state_e       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_c;
  logic [W-1:0] w_max;
  logic [1:0]   w_idx;
  logic         w_accept;
  logic         w_handoff;

  // Ready and valid are pure state decodes: input and output never overlap.
  assign bus.in_ready  = (r_state != S_OUT);
  assign bus.out_valid = (r_state == S_OUT);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_handoff     = bus.out_valid && bus.out_ready;
  assign o_dbg_state   = r_state;

  max3_sel #(.W(W)) u_sel (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_c   (r_c),
    .o_max (w_max),
    .o_idx (w_idx)
  );

  assign bus.out_data = w_max;
  assign bus.out_idx  = w_idx;

  // Sequencer: three loading slots, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_A;
    end else begin
      case (r_state)
        S_A:     if (w_accept)  r_state <= S_B;
        S_B:     if (w_accept)  r_state <= S_C;
        S_C:     if (w_accept)  r_state <= S_OUT;
        S_OUT:   if (w_handoff) r_state <= S_A;
        default:                r_state <= S_A;
      endcase
    end
  end

  // Operand registers: each loads only on an accept in its own slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_A:     r_a <= bus.in_data;
        S_B:     r_b <= bus.in_data;
        S_C:     r_c <= bus.in_data;
        default: ;
      endcase
    end
  end

`ifdef MAX3_RUNNING_EN
  logic [W-1:0] r_run_max;

  // Running peak over handed-off results; clear wins over an update.
  always_ff @(posedge clk) begin
    if (rst || run_clr) begin
      r_run_max <= '0;
    end else if (w_handoff && (w_max > r_run_max)) begin
      r_run_max <= w_max;
    end
  end

  assign run_max = r_run_max;
`endif
endmodule

// File: tb/tb_max3_stream_ctrl.sv
// Self-checking bench for max3_stream_ctrl. Compile with +define+MAX3_RUNNING_EN
// to also exercise the running-peak tracker.
module tb_max3_stream_ctrl;
  import max3_pkg::*;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_clr = 1'b0;
  logic [TW-1:0] run_max;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [TW-1:0] exp_q[$];
  logic [1:0]    exp_idx_q[$];
  logic [TW-1:0] ref_run = '0;

  max3_stream_ctrl_if #(.W(TW)) bus ();

  max3_stream_ctrl #(.W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef MAX3_RUNNING_EN
    .run_clr     (run_clr),
    .run_max     (run_max),
`endif
    .o_dbg_state (dbg_state)
  );

`ifndef MAX3_RUNNING_EN
  assign run_max = '0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_run = '0;
  endtask

  // ---------------- reference model ----------------
  // Maximum of the triple; the first slot holding that maximum wins.
  function automatic void ref_triple(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                     input logic [TW-1:0] c,
                                     output logic [TW-1:0] m, output logic [1:0] idx);
    logic [TW-1:0] v[3];
    v[0] = a; v[1] = b; v[2] = c;
    idx = 2'd0;
    for (int i = 1; i < 3; i++) if (v[i] > v[idx]) idx = 2'(i);
    m = v[idx];
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_sample(input logic [TW-1:0] v, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL load_out_valid got %b need 0", bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_errors++;
      $display("FAIL in_ready_timeout got in_ready=%b after %0d cycles need 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // One full triple: load, optional stall with competing input, handoff, check.
  task automatic run_triple(input logic [TW-1:0] a, input logic [TW-1:0] b,
                            input logic [TW-1:0] c, input int gap, input int stall,
                            input logic clr);
    logic [TW-1:0] m;
    logic [TW-1:0] em;
    logic [1:0]    ix;
    logic [1:0]    eix;
    ref_triple(a, b, c, m, ix);
    exp_q.push_back(m);
    exp_idx_q.push_back(ix);
    bus.out_ready = (stall == 0);
    drive_sample(a, gap);
    drive_sample(b, gap);
    drive_sample(c, gap);
    em  = exp_q.pop_front();
    eix = exp_idx_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = TW'($urandom_range(0, 15));
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hs cyc %0d got valid=%b ready=%b need valid=1 ready=0",
                 s, bus.out_valid, bus.in_ready);
      end
      n_checks++;
      if (bus.out_data !== em || bus.out_idx !== eix) begin
        n_errors++;
        $display("FAIL stall_data cyc %0d got %0d/%0d need %0d/%0d",
                 s, bus.out_data, bus.out_idx, em, eix);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    run_clr       = clr;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL out_valid got %b need 1 (triple %0d,%0d,%0d)", bus.out_valid, a, b, c);
    end
    n_checks++;
    if (bus.out_data !== em) begin
      n_errors++;
      $display("FAIL out_data got %0d need %0d (triple %0d,%0d,%0d)", bus.out_data, em, a, b, c);
    end
    n_checks++;
    if (bus.out_idx !== eix) begin
      n_errors++;
      $display("FAIL out_idx got %0d need %0d (triple %0d,%0d,%0d)", bus.out_idx, eix, a, b, c);
    end
    @(posedge clk);
    #1;
    run_clr = 1'b0;
    if (clr) ref_run = '0;
    else if (em > ref_run) ref_run = em;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL after_handoff got valid=%b ready=%b need valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
`ifdef MAX3_RUNNING_EN
    n_checks++;
    if (run_max !== ref_run) begin
      n_errors++;
      $display("FAIL run_max got %0d need %0d", run_max, ref_run);
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs got ready=%b valid=%b need ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0 || bus.out_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_out got %0d/%0d need 0/0", bus.out_data, bus.out_idx);
    end
    n_checks++;
    if (dbg_state !== S_A) begin
      n_errors++;
      $display("FAIL reset_state got %0d need %0d", dbg_state, S_A);
    end
`ifdef MAX3_RUNNING_EN
    n_checks++;
    if (run_max !== '0) begin
      n_errors++;
      $display("FAIL reset_run_max got %0d need 0", run_max);
    end
`endif
  endtask

  task automatic test_distinct();
    run_triple(4'd3, 4'd9, 4'd5, 0, 0, 1'b0);
  endtask

  task automatic test_ties();
    run_triple(4'd7, 4'd7, 4'd7, 0, 0, 1'b0);
    run_triple(4'd2, 4'd6, 4'd6, 0, 0, 1'b0);
    run_triple(4'd15, 4'd0, 4'd15, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_triple(4'd1, 4'd2, 4'd4, 0, 5, 1'b0);
    run_triple(4'd6, 4'd3, 4'd1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_sample(4'd14, 0);
    drive_sample(4'd13, 0);
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== S_A) begin
      n_errors++;
      $display("FAIL mid_reset got valid=%b ready=%b state=%0d need 0/1/%0d",
               bus.out_valid, bus.in_ready, dbg_state, S_A);
    end
    run_triple(4'd0, 4'd0, 4'd1, 0, 0, 1'b0);
    drive_sample(4'd12, 0);
    drive_sample(4'd11, 0);
    do_reset();
    run_triple(4'd0, 4'd0, 4'd1, 3, 0, 1'b0);
    // Reset while a result is pending drops it.
    bus.out_ready = 1'b0;
    drive_sample(4'd9, 0);
    drive_sample(4'd10, 0);
    drive_sample(4'd8, 0);
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL out_reset got valid=%b data=%0d idx=%0d need 0/0/0",
               bus.out_valid, bus.out_data, bus.out_idx);
    end
    run_triple(4'd0, 4'd0, 4'd1, 1, 0, 1'b0);
  endtask

`ifdef MAX3_RUNNING_EN
  task automatic test_running();
    do_reset();
    run_triple(4'd5, 4'd1, 4'd2, 0, 0, 1'b0);
    run_triple(4'd3, 4'd12, 4'd0, 0, 0, 1'b0);
    run_triple(4'd8, 4'd8, 4'd1, 0, 2, 1'b0);
    run_triple(4'd4, 4'd2, 4'd9, 0, 0, 1'b1);
    run_triple(4'd1, 4'd3, 4'd2, 0, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic clr;
    for (int t = 0; t < 25; t++) begin
      clr = 1'b0;
`ifdef MAX3_RUNNING_EN
      clr = ($urandom_range(0, 7) == 0);
`endif
      run_triple(TW'($urandom_range(0, 15)), TW'($urandom_range(0, 15)),
                 TW'($urandom_range(0, 15)), $urandom_range(0, 2),
                 $urandom_range(0, 3), clr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_distinct();
    test_ties();
    test_backpressure();
    test_reset_mid();
`ifdef MAX3_RUNNING_EN
    test_running();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
